// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: runs the layer engines one at a time through level start/done
// handshakes, with a per-stage watchdog and a one-cycle run_done pulse on completion.
// Optional per-stage cycle profiling is built when CYCLE_PROFILE_EN is defined.
module cnn_layer_sequencer #(
    parameter int          NUM_STAGES = 5,
    parameter int unsigned TIMEOUT    = 20'd1_000_000,
    parameter int          CNT_W      = 24,
    localparam int         STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        run_start,
    input  logic                        abort,
    input  logic [NUM_STAGES-1:0]       stage_done,
    output logic [NUM_STAGES-1:0]       stage_start,
    output logic                        busy,
    output logic                        run_done,
    output logic                        error,
    output logic [STG_W-1:0]            err_stage,
`ifdef CYCLE_PROFILE_EN
    output logic [STG_W-1:0]            cur_stage,
    output logic [NUM_STAGES*CNT_W-1:0] stage_cycles
`else
    output logic [STG_W-1:0]            cur_stage
`endif
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, RUN, RELEASE, FINISH, ERROR} state_t;

    state_t          state;
    logic [WD_W-1:0] wd;
    logic            done_cur;
    logic            last;
    logic            enter_run;
    logic [STG_W-1:0] run_idx;

    // Decode the current stage's done, and whether/which stage enters RUN on the next edge.
    always_comb begin
        done_cur  = stage_done[cur_stage];
        last      = cur_stage == STG_W'(NUM_STAGES - 1);
        enter_run = !abort && ((((state == IDLE) || (state == ERROR)) && run_start) ||
                               ((state == RELEASE) && !done_cur && !last));
        run_idx   = (state == RELEASE) ? cur_stage + STG_W'(1) : '0;
    end

    // Sequencer FSM with registered outputs; abort overrides every transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            stage_start <= '0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            error       <= 1'b0;
            err_stage   <= '0;
            cur_stage   <= '0;
            wd          <= '0;
        end else if (abort) begin
            state       <= IDLE;
            stage_start <= '0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            cur_stage   <= '0;
        end else if (enter_run) begin
            state       <= RUN;
            stage_start <= NUM_STAGES'(1) << run_idx;
            cur_stage   <= run_idx;
            busy        <= 1'b1;
            wd          <= '0;
            if (state == ERROR) begin
                error     <= 1'b0;
                err_stage <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (done_cur) begin
                        state       <= RELEASE;
                        stage_start <= '0;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        state       <= ERROR;
                        stage_start <= '0;
                        busy        <= 1'b0;
                        error       <= 1'b1;
                        err_stage   <= cur_stage;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                RELEASE: begin
                    if (!done_cur && last) begin
                        state     <= FINISH;
                        run_done  <= 1'b1;
                        busy      <= 1'b0;
                        cur_stage <= '0;
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    run_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef CYCLE_PROFILE_EN
    // Per-stage RUN cycle counters: cleared on entry to RUN, saturating, frozen otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_cycles <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if ((state == RUN) && (cur_stage == STG_W'(k)))
                    stage_cycles[k*CNT_W +: CNT_W] <= stage_cycles[k*CNT_W +: CNT_W] +
                        CNT_W'(stage_cycles[k*CNT_W +: CNT_W] != {CNT_W{1'b1}});
                else if (enter_run && (run_idx == STG_W'(k)))
                    stage_cycles[k*CNT_W +: CNT_W] <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed bench with behavioural layer engines and exact cycle timing.
module tb_cnn_layer_sequencer;

    localparam int N  = 5;
    localparam int TO = 64;
    localparam int CW = 24;
    localparam int SW = 3;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          run_start = 1'b0;
    logic          abort     = 1'b0;
    logic [N-1:0]  eng_done  = '0;
    logic [N-1:0]  stray     = '0;
    logic [N-1:0]  stage_done;
    logic [N-1:0]  stage_start;
    logic          busy, run_done, error;
    logic [SW-1:0] err_stage, cur_stage;
`ifdef CYCLE_PROFILE_EN
    logic [N*CW-1:0] stage_cycles;
`endif

    int checks    = 0;
    int errors    = 0;
    int rd_pulses = 0;
    int hold[N];
    bit never[N];
    int cnt[N];
    int hc[N];

    assign stage_done = eng_done | stray;

    always #5 clk = ~clk;

    cnn_layer_sequencer #(.NUM_STAGES(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .run_start(run_start),
        .abort(abort),
        .stage_done(stage_done),
        .stage_start(stage_start),
        .busy(busy),
        .run_done(run_done),
        .error(error),
        .err_stage(err_stage),
`ifdef CYCLE_PROFILE_EN
        .cur_stage(cur_stage),
        .stage_cycles(stage_cycles)
`else
        .cur_stage(cur_stage)
`endif
    );

    // Engines: done rises 10 cycles after start is seen, falls hold[k] cycles after start drops.
    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (!reset_n) begin
                eng_done[k] = 1'b0;
                cnt[k] = 0;
                hc[k] = 0;
            end else if (stage_start[k]) begin
                hc[k] = 0;
                if (!never[k]) begin
                    if (cnt[k] == 10) eng_done[k] = 1'b1;
                    else cnt[k]++;
                end
            end else if (eng_done[k]) begin
                if (hc[k] == hold[k]) begin
                    eng_done[k] = 1'b0;
                    hc[k] = 0;
                    cnt[k] = 0;
                end else begin
                    hc[k]++;
                end
            end else begin
                cnt[k] = 0;
            end
        end
    end

    // Every cycle: at most one start bit, and count run_done pulses.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert ($countones(stage_start) <= 1) else begin
                errors++;
                $error("FAIL onehot observed %b expected at most one bit set", stage_start);
            end
            if (run_done) rd_pulses++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        run_start = 1'b1;
        tick(1);
        run_start = 1'b0;
    endtask

    task automatic chk_prof(input int exp);
`ifdef CYCLE_PROFILE_EN
        for (int k = 0; k < N; k++) chk($sformatf("prof%0d", k), 32'(stage_cycles[k*CW +: CW]), exp);
`else
        chk("prof_absent_busy", 32'(busy), 0);
`endif
    endtask

    // Full run with 13-cycle stage period; noise adds a stray done and a repeated run_start.
    task automatic normal_run(input bit noise);
        int rd0;
        rd0 = rd_pulses;
        start_run();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("start_on%0d", k), 32'(stage_start), 32'(1 << k));
            chk($sformatf("cur%0d", k), 32'(cur_stage), k);
            chk($sformatf("busy%0d", k), 32'(busy), 1);
            if (noise && k == 0) begin
                stray = 5'b10000;
                tick(3);
                stray = '0;
                tick(7);
            end else if (noise && k == 1) begin
                tick(2);
                run_start = 1'b1;
                tick(1);
                run_start = 1'b0;
                tick(7);
            end else begin
                tick(10);
            end
            chk($sformatf("start_hold%0d", k), 32'(stage_start), 32'(1 << k));
            tick(1);
            chk($sformatf("start_drop%0d", k), 32'(stage_start), 0);
            chk($sformatf("rd_low%0d", k), 32'(run_done), 0);
            tick(1);
            chk($sformatf("start_gap%0d", k), 32'(stage_start), 0);
            tick(1);
        end
        chk("fin_run_done", 32'(run_done), 1);
        chk("fin_busy", 32'(busy), 0);
        chk("fin_cur", 32'(cur_stage), 0);
        chk("fin_start", 32'(stage_start), 0);
        tick(1);
        chk("fin_rd_drop", 32'(run_done), 0);
        chk("fin_rd_count", rd_pulses, rd0 + 1);
        chk_prof(11);
    endtask

    initial begin
        int rd0;
        for (int k = 0; k < N; k++) begin
            hold[k] = 1;
            never[k] = 1'b0;
        end
        tick(1);
        chk("rst_start", 32'(stage_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_run_done", 32'(run_done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_stage", 32'(err_stage), 0);
        chk("rst_cur", 32'(cur_stage), 0);
        chk_prof(0);
        reset_n = 1'b1;
        tick(1);

        normal_run(1'b0);
        normal_run(1'b1);

        // Stage 3 hangs: timeout 64 cycles after its start rises.
        never[3] = 1'b1;
        rd0 = rd_pulses;
        start_run();
        tick(102);
        chk("to_pre_start", 32'(stage_start), 32'h8);
        chk("to_pre_error", 32'(error), 0);
        tick(1);
        chk("to_error", 32'(error), 1);
        chk("to_err_stage", 32'(err_stage), 3);
        chk("to_start", 32'(stage_start), 0);
        chk("to_busy", 32'(busy), 0);
        tick(5);
        chk("to_sticky", 32'(error), 1);
        chk("to_no_rd", rd_pulses, rd0);
        never[3] = 1'b0;

        // Restart from ERROR, then abort during stage 2.
        start_run();
        chk("rs_error", 32'(error), 0);
        chk("rs_err_stage", 32'(err_stage), 0);
        chk("rs_start", 32'(stage_start), 1);
        chk("rs_busy", 32'(busy), 1);
        tick(30);
        chk("ab_pre_start", 32'(stage_start), 32'h4);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("ab_start", 32'(stage_start), 0);
        chk("ab_busy", 32'(busy), 0);
        chk("ab_cur", 32'(cur_stage), 0);
        chk("ab_error", 32'(error), 0);
        tick(20);
        chk("ab_idle_start", 32'(stage_start), 0);
        chk("ab_idle_busy", 32'(busy), 0);
        chk("ab_no_rd", rd_pulses, rd0);

        // abort and run_start together in IDLE: stay idle.
        run_start = 1'b1;
        abort = 1'b1;
        tick(1);
        run_start = 1'b0;
        abort = 1'b0;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_start", 32'(stage_start), 0);
        tick(1);
        chk("ar_busy2", 32'(busy), 0);

        // Stage 1 holds done 5 cycles after start falls.
        hold[1] = 5;
        start_run();
        tick(29);
        chk("hd_wait_start", 32'(stage_start), 0);
        chk("hd_wait_cur", 32'(cur_stage), 1);
        tick(1);
        chk("hd_next_start", 32'(stage_start), 32'h4);
        chk("hd_next_cur", 32'(cur_stage), 2);
        tick(39);
        chk("hd_run_done", 32'(run_done), 1);
        chk("hd_busy", 32'(busy), 0);
        hold[1] = 1;
        tick(1);
        chk_prof(11);

        // Asynchronous reset during stage 2, then a clean run.
        start_run();
        tick(30);
        chk("ar2_pre_start", 32'(stage_start), 32'h4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ra_start", 32'(stage_start), 0);
        chk("ra_busy", 32'(busy), 0);
        chk("ra_cur", 32'(cur_stage), 0);
        chk("ra_error", 32'(error), 0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        chk("ra_idle_busy", 32'(busy), 0);
        normal_run(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
